frequency_generator: RTL and testbench
======================================

# frequency_generator

Programmable square-wave source that drives a test signal at a known frequency into the frequency counter's `signal` input, for on-chip loopback and self-test. Its half-period is set through a load strobe, and its controls are wired from the logic analyzer bits. It runs in one of two modes: continuous output, or a burst of exactly N pulses. It reports how many pulses it has produced.

## Interface
- `WIDTH`, 12: width of `half_period`, matching the counter's `period` field.
- `CNT_W`, 8: width of `burst_len` and `pulse_count`.

Ports (clock and reset first):
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  high for one cycle captures `half_period` into the shadow register.
- `half_period`  in  WIDTH  length of each phase in clk cycles; 0 is stored as 1.
- `enable`  in  1  level; runs continuous mode while high.
- `start`  in  1  high for one cycle starts a burst; ignored unless IDLE.
- `burst_len`  in  CNT_W  number of high pulses in a burst, sampled on `start`.
- `signal`  out  1  generated square wave, registered.
- `busy`  out  1  high when the state is not IDLE, registered.
- `done`  out  1  one-cycle pulse when a burst ends.
- `pulse_count`  out  CNT_W  number of high->low transitions since the last start of a run.

## Operation
- **Registers:**
  - `shadow_h`, `active_h` (both WIDTH), phase counter `cnt` (WIDTH), `remaining` (CNT_W).
  - States: IDLE, RUN (continuous), BURST.
- **Load:**
  - `load`=1 writes `max(half_period,1)` to `shadow_h`.
  - In IDLE, `active_h` is also written on the same edge.
  - In RUN or BURST, `active_h <= shadow_h` only at a toggle point, so there are no glitches or truncated phases.
- **IDLE:**
  - `signal`=0.
  - `start`=1 with `burst_len`>0: `signal<=1`, `cnt<=active_h-1`, `remaining<=burst_len`, `pulse_count<=0`, go to BURST.
  - `start`=1 with `burst_len`=0: `done<=1` on the next edge and stay in IDLE. `pulse_count<=0`. No pulse is produced.
  - Otherwise, `enable`=1: `signal<=1`, `cnt<=active_h-1`, `pulse_count<=0`, go to RUN.
  - `start` takes priority over `enable` when both are high in the same cycle.
- **RUN / BURST, per clock edge:**
  - If `cnt`≠0: `cnt<=cnt-1`.
  - If `cnt`=0 (toggle point): take `h = shadow_h`, set `active_h<=h`, `cnt<=h-1`, and toggle `signal`.
  - A 1->0 toggle increments `pulse_count`, wrapping modulo 2^CNT_W.
- **RUN exit:**
  - At a toggle point with `enable`=0, go to IDLE with `signal<=0`.
  - If `signal` was 1, this is its normal fall and it counts as a pulse.
  - If `signal` was 0, it stays 0.
  - No high phase is ever shortened.
- **BURST:**
  - `enable` is ignored.
  - At each 1->0 toggle, `remaining` is decremented.
  - At the 1->0 toggle with `remaining`=1: `signal<=0`, `done<=1`, go to IDLE. The trailing low phase is not generated.
- **`done`:** high for exactly one cycle, then cleared.
- **Reset** (asynchronous; applies to any state, including mid-burst):
  - State IDLE.
  - `signal`=0, `busy`=0, `done`=0, `pulse_count`=0, `remaining`=0, `cnt`=0.
  - `shadow_h`=`active_h`=1.

## Timing
- **Start latency:** `signal` rises on the edge that samples `start`/`enable` in IDLE, i.e. visible 1 cycle after the control is asserted. `busy` rises on the same edge.
- **Waveform:** high for exactly H cycles, then low for exactly H cycles; period 2H; H=1 gives `signal` at clk/2.
- **Load latency:**
  - From IDLE, a load followed by enable on the next cycle uses the new H.
  - During a run, the new H applies from the phase after the current one completes.
  - A load in the same cycle as a toggle point uses the old `shadow_h` for that toggle.
- **Burst length:** the final falling edge is (2N-1)·H cycles after `signal` rises. `done` is high for the cycle in which `signal` is first 0 after that edge, and `busy` is 0 in that same cycle.
- **Idle gap:** a new `start` is accepted in the cycle `done` is high. The minimum gap between bursts is 1 cycle.
- **`pulse_count`:** updates on the same edge as the falling `signal` transition.

## Test plan
- Reset, `load` H=3, `enable`=1 for 40 cycles -> `signal` is 3 high / 3 low starting 1 cycle after `enable`; `pulse_count` increments every 6 cycles; `busy`=1.
- H=2, `start` with `burst_len`=4 -> exactly 4 high pulses of 2 cycles each; `done` is a single-cycle pulse 14 cycles after the first rise; `pulse_count`=4; `start` is ignored while `busy`=1.
- Running continuously at H=5, `load` H=2 mid high phase -> that phase still lasts 5 cycles, then 2-cycle phases follow; no runt pulses.
- Drop `enable` 1 cycle into a 4-cycle high phase -> high lasts the full 4 cycles, then `signal`=0 and `busy`=0; also check dropping `enable` during a low phase, which must end after the full low phase.
- `burst_len`=0 -> no `signal` activity and `done` pulses once. `half_period`=0 loaded -> behaves as H=1 (clk/2). `pulse_count` wraps 255->0 in continuous mode.
- Assert `reset_n`=0 asynchronously mid-burst while `signal`=1 -> `signal`, `busy`, `done` and `pulse_count` go to 0 without waiting for a clock edge; after release, a new `start` runs with H=1.

Source files
------------

// File: rtl/frequency_generator.sv
// Programmable square-wave source (continuous or N-pulse burst) for loopback/self-test.
// Latency: signal/busy rise on the edge that samples start/enable in IDLE; outputs registered.
// Backpressure: none; start is ignored unless IDLE, enable is ignored during a burst.
module frequency_generator #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] half_period,
  input  logic             enable,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             signal,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shadow_h;
  logic [WIDTH-1:0] r_active_h;
  logic [WIDTH-1:0] r_cnt;
  logic [CNT_W-1:0] r_remaining;
  logic             r_signal;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_pulse_count;

  // A zero half-period would stall the phase counter, so it is stored as 1.
  logic [WIDTH-1:0] w_load_h;
  logic             w_toggle;
  logic [WIDTH-1:0] w_shadow_m1;
  logic [WIDTH-1:0] w_active_m1;
  logic             w_last_pulse;

  assign w_load_h     = (half_period == '0) ? WIDTH'(1) : half_period;
  assign w_toggle     = (r_cnt == '0);
  assign w_shadow_m1  = r_shadow_h - WIDTH'(1);
  assign w_active_m1  = r_active_h - WIDTH'(1);
  assign w_last_pulse = (r_remaining == CNT_W'(1));

  assign signal      = r_signal;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pulse_count = r_pulse_count;

  // Shadow half-period: captured on every load regardless of state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow_h <= WIDTH'(1);
    end else if (load) begin
      r_shadow_h <= w_load_h;
    end
  end

  // Main control FSM: phase counting, toggling, burst accounting and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_active_h    <= WIDTH'(1);
      r_cnt         <= '0;
      r_remaining   <= '0;
      r_signal      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pulse_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Nothing is running, so a new half-period can take effect at once.
          if (load) begin
            r_active_h <= w_load_h;
          end
          if (start) begin
            r_pulse_count <= '0;
            if (burst_len != '0) begin
              r_signal    <= 1'b1;
              r_busy      <= 1'b1;
              r_cnt       <= w_active_m1;
              r_remaining <= burst_len;
              r_state     <= S_BURST;
            end else begin
              // Empty burst: report completion without producing a pulse.
              r_done <= 1'b1;
            end
          end else if (enable) begin
            r_signal      <= 1'b1;
            r_busy        <= 1'b1;
            r_cnt         <= w_active_m1;
            r_pulse_count <= '0;
            r_state       <= S_RUN;
          end
        end

        S_RUN: begin
          if (!w_toggle) begin
            r_cnt <= r_cnt - WIDTH'(1);
          end else begin
            // Phase boundary: adopt the pending half-period so no phase is truncated.
            r_active_h <= r_shadow_h;
            r_cnt      <= w_shadow_m1;
            if (r_signal) begin
              r_pulse_count <= r_pulse_count + CNT_W'(1);
            end
            if (!enable) begin
              // Stop only at a boundary; a high phase ends as its normal fall.
              r_signal <= 1'b0;
              r_busy   <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_signal <= ~r_signal;
            end
          end
        end

        S_BURST: begin
          if (!w_toggle) begin
            r_cnt <= r_cnt - WIDTH'(1);
          end else begin
            r_active_h <= r_shadow_h;
            r_cnt      <= w_shadow_m1;
            if (r_signal) begin
              r_pulse_count <= r_pulse_count + CNT_W'(1);
              r_remaining   <= r_remaining - CNT_W'(1);
              r_signal      <= 1'b0;
              if (w_last_pulse) begin
                // Last fall: the trailing low phase is skipped.
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_signal <= 1'b1;
            end
          end
        end

        default: begin
          r_signal <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_generator.sv
// Self-checking bench for frequency_generator: directed scenarios plus random control traffic.
// Latency: model advances on each rising edge; outputs compared on the falling edge.
// Backpressure: none; stimulus is driven freely on the falling edge.
module tb_frequency_generator;

  localparam int WIDTH = 12;
  localparam int CNT_W = 8;

  logic             clk;
  logic             reset_n;
  logic             load;
  logic [WIDTH-1:0] half_period;
  logic             enable;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic             signal;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_count;

  frequency_generator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .half_period (half_period),
    .enable      (enable),
    .start       (start),
    .burst_len   (burst_len),
    .signal      (signal),
    .busy        (busy),
    .done        (done),
    .pulse_count (pulse_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt;
  int bad_cnt;

  // Reference model: mode, current level, phase length and elapsed cycles in it.
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_BURST = 2;

  int m_mode;
  int m_level;
  int m_len;
  int m_age;
  int m_left;
  int m_shadow;
  int m_active;
  int m_count;
  int m_done;

  task automatic chk(input string tag, input int got, input int exp);
    total_cnt++;
    if (got != exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_level  = 0;
    m_len    = 1;
    m_age    = 0;
    m_left   = 0;
    m_shadow = 1;
    m_active = 1;
    m_count  = 0;
    m_done   = 0;
  endtask

  task automatic model_step();
    int old_shadow;
    int old_active;
    old_shadow = m_shadow;
    old_active = m_active;
    if (load) m_shadow = (half_period == 0) ? 1 : int'(half_period);
    m_done = 0;
    if (m_mode == M_IDLE) begin
      if (load) m_active = m_shadow;
      if (start) begin
        m_count = 0;
        if (burst_len != 0) begin
          m_mode  = M_BURST;
          m_level = 1;
          m_len   = old_active;
          m_age   = 0;
          m_left  = int'(burst_len);
        end else begin
          m_done = 1;
        end
      end else if (enable) begin
        m_mode  = M_RUN;
        m_level = 1;
        m_len   = old_active;
        m_age   = 0;
        m_count = 0;
      end
    end else begin
      m_age++;
      if (m_age == m_len) begin
        // Phase finished after exactly m_len cycles; the next one uses the pending length.
        m_age    = 0;
        m_len    = old_shadow;
        m_active = old_shadow;
        if (m_level == 1) m_count = (m_count + 1) % (1 << CNT_W);
        if (m_mode == M_BURST) begin
          if (m_level == 1) begin
            m_left--;
            if (m_left == 0) begin
              m_mode = M_IDLE;
              m_done = 1;
            end
          end
          m_level = (m_level == 1) ? 0 : 1;
        end else if (!enable) begin
          m_mode  = M_IDLE;
          m_level = 0;
        end else begin
          m_level = (m_level == 1) ? 0 : 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_signal"}, int'(signal), m_level);
    chk({pfx, "_busy"}, int'(busy), (m_mode != M_IDLE) ? 1 : 0);
    chk({pfx, "_done"}, int'(done), m_done);
    chk({pfx, "_pcount"}, int'(pulse_count), m_count);
  endtask

  // One clock: model follows the DUT edge, comparison on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic do_load(input int h);
    load = 1'b1;
    half_period = WIDTH'(h);
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    burst_len = CNT_W'(n);
    cyc();
    start = 1'b0;
  endtask

  int t;

  initial begin
    total_cnt   = 0;
    bad_cnt     = 0;
    reset_n     = 1'b0;
    load        = 1'b0;
    half_period = '0;
    enable      = 1'b0;
    start       = 1'b0;
    burst_len   = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset_n = 1'b1;
    cyc();

    // Continuous H=3
    do_load(3);
    enable = 1'b1;
    repeat (40) cyc();
    enable = 1'b0;
    repeat (8) cyc();

    // Burst H=2, N=4, with an extra start while busy
    do_load(2);
    do_start(4);
    t = 0;
    while (!done && t < 40) begin
      start = (t == 3);
      burst_len = 8'd7;
      cyc();
      t++;
    end
    start = 1'b0;
    chk("burst_rise_to_done", t, 14);
    chk("burst_pulses", int'(pulse_count), 4);
    repeat (3) cyc();

    // H=5 running, load H=2 mid high phase
    do_load(5);
    enable = 1'b1;
    cyc();
    cyc();
    do_load(2);
    repeat (20) cyc();
    enable = 1'b0;
    repeat (8) cyc();

    // H=4: drop enable 1 cycle into the high phase, then during a low phase
    do_load(4);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    repeat (8) cyc();
    enable = 1'b1;
    repeat (6) cyc();
    enable = 1'b0;
    repeat (8) cyc();

    // Empty burst, then H=0 behaves as H=1
    do_start(0);
    repeat (3) cyc();
    do_load(0);
    enable = 1'b1;
    repeat (10) cyc();
    enable = 1'b0;
    repeat (3) cyc();

    // Pulse counter wrap at H=1
    enable = 1'b1;
    repeat (530) cyc();
    enable = 1'b0;
    repeat (3) cyc();

    // Asynchronous reset mid-burst while signal is high
    do_load(3);
    do_start(5);
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    cyc();
    reset_n = 1'b1;
    cyc();
    do_start(2);
    repeat (6) cyc();

    // Random control traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: do_load($urandom_range(0, 7));
        1: enable = 1'($urandom_range(0, 1));
        2: do_start($urandom_range(0, 5));
        default: ;
      endcase
      repeat ($urandom_range(1, 25)) cyc();
    end
    enable = 1'b0;
    repeat (40) cyc();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
